// File: rtl/rf_pkg.sv
// Shared sizing and constants for the register file / scoreboard slice.
package rf_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;
  localparam int CNT_W  = 16;
  localparam logic [ADDR_W-1:0] R0 = '0;
endpackage

// File: rtl/regfile_array.sv
// Architectural register storage: one write port, two read ports with
// same-cycle write-back bypass and a hardwired-zero r0.
module regfile_array
  import rf_pkg::*;
#(
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int ADDR_W = rf_pkg::ADDR_W,
  parameter int NREGS  = rf_pkg::NREGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b
);

  logic [DATA_W-1:0] r_mem [NREGS];
  logic              w_wr_en;

  assign w_wr_en = i_we && (i_waddr != R0);

  // NOTE: the storage is reset explicitly because every register must read
  // zero after reset; this forces flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // NOTE: each output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    o_rdata_a = r_mem[i_raddr_a];
    if (i_raddr_a == R0)                          o_rdata_a = '0;
    else if (i_we && (i_waddr == i_raddr_a))      o_rdata_a = i_wdata;
  end

  always_comb begin
    o_rdata_b = r_mem[i_raddr_b];
    if (i_raddr_b == R0)                          o_rdata_b = '0;
    else if (i_we && (i_waddr == i_raddr_b))      o_rdata_b = i_wdata;
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with pending-write scoreboard: gates issue on RAW/WAW hazards,
// tracks outstanding writes until write-back, flags spurious write-backs.
module regfile_sb
  import rf_pkg::*;
#(
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int ADDR_W = rf_pkg::ADDR_W,
  parameter int NREGS  = rf_pkg::NREGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              rs_used,
  input  logic              rt_used,
  input  logic              dst_valid,
  input  logic [ADDR_W-1:0] dst_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [NREGS-1:0]  pending,
  output logic              wb_err,
  output logic [CNT_W-1:0]  stall_cnt
);

  if (NREGS != 2**ADDR_W) begin : g_bad_size
    $error("regfile_sb: NREGS must equal 2**ADDR_W");
  end

  logic [NREGS-1:0] r_pending;
  logic [NREGS-1:0] w_pending_nxt;
  logic             r_wb_err;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_wb_any, w_rs_haz, w_rt_haz, w_waw_haz, w_accept, w_stall;

  regfile_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (wb_valid),
    .i_waddr   (wb_addr),
    .i_wdata   (wb_data),
    .i_raddr_a (rs_addr),
    .o_rdata_a (rs_data),
    .i_raddr_b (rt_addr),
    .o_rdata_b (rt_data)
  );

  // A write-back landing this cycle resolves its own hazard via the bypass.
  assign w_wb_any  = wb_valid && (wb_addr != R0);
  assign w_rs_haz  = rs_used && r_pending[rs_addr] && !(wb_valid && (wb_addr == rs_addr));
  assign w_rt_haz  = rt_used && r_pending[rt_addr] && !(wb_valid && (wb_addr == rt_addr));
  assign w_waw_haz = issue_valid && dst_valid && (dst_addr != R0) && r_pending[dst_addr]
                     && !(wb_valid && (wb_addr == dst_addr));

  assign issue_ready = !(w_rs_haz || w_rt_haz || w_waw_haz);
  assign w_accept    = issue_valid && issue_ready && dst_valid && (dst_addr != R0);
  assign w_stall     = issue_valid && !issue_ready;

  // Set is applied after clear so a back-to-back producer keeps its bit.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_wb_any) w_pending_nxt[wb_addr]  = 1'b0;
    if (w_accept) w_pending_nxt[dst_addr] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending   <= '0;
      r_wb_err    <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_wb_any && !r_pending[wb_addr]) r_wb_err <= 1'b1;
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign pending   = r_pending;
  assign wb_err    = r_wb_err;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized
// traffic against an array/bit-vector reference model.
module tb_regfile_sb;
  import rf_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              issue_valid, issue_ready;
  logic [ADDR_W-1:0] rs_addr, rt_addr, dst_addr, wb_addr;
  logic              rs_used, rt_used, dst_valid, wb_valid;
  logic [DATA_W-1:0] rs_data, rt_data, wb_data;
  logic [NREGS-1:0]  pending;
  logic              wb_err;
  logic [15:0]       stall_cnt;

  regfile_sb dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .rs_used     (rs_used),
    .rt_used     (rt_used),
    .dst_valid   (dst_valid),
    .dst_addr    (dst_addr),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .pending     (pending),
    .wb_err      (wb_err),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain arrays and counters.
  logic [DATA_W-1:0] m_mem [NREGS];
  logic [NREGS-1:0]  m_pend;
  logic              m_err;
  int                m_stall;

  task automatic m_reset();
    for (int i = 0; i < NREGS; i++) m_mem[i] = '0;
    m_pend  = '0;
    m_err   = 1'b0;
    m_stall = 0;
  endtask

  function automatic logic [DATA_W-1:0] m_read(input logic [ADDR_W-1:0] a);
    if (a == 0) return '0;
    if (wb_valid && wb_addr == a) return wb_data;
    return m_mem[a];
  endfunction

  function automatic logic m_ready();
    bit blk_rs, blk_rt, blk_waw;
    blk_rs  = rs_used && m_pend[rs_addr] && !(wb_valid && wb_addr == rs_addr);
    blk_rt  = rt_used && m_pend[rt_addr] && !(wb_valid && wb_addr == rt_addr);
    blk_waw = issue_valid && dst_valid && dst_addr != 0 && m_pend[dst_addr]
              && !(wb_valid && wb_addr == dst_addr);
    return !(blk_rs || blk_rt || blk_waw);
  endfunction

  task automatic drive(input logic iv, input int rs, input logic rsu, input int rt,
                       input logic rtu, input logic dv, input int dst,
                       input logic wv, input int wa, input logic [DATA_W-1:0] wd);
    issue_valid = iv;
    rs_addr = ADDR_W'(rs); rs_used = rsu;
    rt_addr = ADDR_W'(rt); rt_used = rtu;
    dst_valid = dv; dst_addr = ADDR_W'(dst);
    wb_valid = wv; wb_addr = ADDR_W'(wa); wb_data = wd;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
  endtask

  // Compare all outputs to the model, advance model and DUT by one clock.
  task automatic cycle();
    logic rdy;
    rdy = m_ready();
    check("issue_ready", 64'(issue_ready), 64'(rdy));
    check("rs_data", 64'(rs_data), 64'(m_read(rs_addr)));
    check("rt_data", 64'(rt_data), 64'(m_read(rt_addr)));
    check("pending", 64'(pending), 64'(m_pend));
    check("wb_err", 64'(wb_err), 64'(m_err));
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    if (wb_valid && wb_addr != 0) begin
      if (!m_pend[wb_addr]) m_err = 1'b1;
      m_mem[wb_addr]  = wb_data;
      m_pend[wb_addr] = 1'b0;
    end
    if (issue_valid && rdy && dst_valid && dst_addr != 0) m_pend[dst_addr] = 1'b1;
    if (issue_valid && !rdy && m_stall < 65535) m_stall++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pick;
    rst_n = 1'b0;
    idle();
    m_reset();
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Write-back then read, r0 immunity.
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0, '0); #2; cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF); #2; cycle();
    drive(0, 5, 1, 0, 0, 0, 0, 1, 0, 32'h1234); #2;
    check("read_r5", 64'(rs_data), 64'hDEADBEEF);
    check("r0_bypass", 64'(rt_data), 64'h0);
    cycle();
    drive(0, 5, 1, 0, 1, 0, 0, 0, 0, '0); #2;
    check("r0_after_wb", 64'(rt_data), 64'h0);
    check("no_err_r0_wb", 64'(wb_err), 64'h0);
    cycle();

    // RAW stall resolved by same-cycle write-back.
    drive(1, 0, 0, 0, 0, 1, 7, 0, 0, '0); #2; cycle();
    drive(1, 7, 1, 0, 0, 0, 0, 0, 0, '0); #2;
    check("raw_stall", 64'(issue_ready), 64'h0);
    cycle(); cycle();
    check("raw_stall_cnt", 64'(stall_cnt), 64'd2);
    drive(1, 7, 1, 0, 0, 0, 0, 1, 7, 32'h55); #2;
    check("raw_wb_ready", 64'(issue_ready), 64'h1);
    check("raw_wb_bypass", 64'(rs_data), 64'h55);
    cycle();

    // WAW stall, then back-to-back producer keeps pending set.
    drive(1, 0, 0, 0, 0, 1, 9, 0, 0, '0); #2; cycle();
    drive(1, 0, 0, 0, 0, 1, 9, 0, 0, '0); #2;
    check("waw_stall", 64'(issue_ready), 64'h0);
    cycle(); cycle();
    drive(1, 0, 0, 0, 0, 1, 9, 1, 9, 32'h99); #2;
    check("waw_wb_ready", 64'(issue_ready), 64'h1);
    cycle();
    check("set_wins", 64'(pending[9]), 64'h1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h9A); #2; cycle();
    check("r9_cleared", 64'(pending[9]), 64'h0);

    // Unused source does not stall.
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0, '0); #2; cycle();
    drive(1, 3, 0, 3, 0, 0, 0, 0, 0, '0); #2;
    check("unused_src", 64'(issue_ready), 64'h1);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h33); #2; cycle();
    check("err_clean", 64'(wb_err), 64'h0);

    // Spurious write-back: data lands, error is sticky.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 12, 32'hA5A5A5A5); #2; cycle();
    check("spur_err", 64'(wb_err), 64'h1);
    drive(0, 12, 1, 0, 0, 0, 0, 0, 0, '0); #2;
    check("spur_data", 64'(rs_data), 64'hA5A5A5A5);
    cycle();
    check("spur_sticky", 64'(wb_err), 64'h1);

    // Randomized traffic over a narrow address window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      issue_valid = ($urandom_range(0, 3) != 0);
      rs_addr   = ADDR_W'($urandom_range(0, 7));
      rt_addr   = ADDR_W'($urandom_range(0, 7));
      rs_used   = 1'($urandom);
      rt_used   = 1'($urandom);
      dst_valid = 1'($urandom);
      dst_addr  = ADDR_W'($urandom_range(0, 7));
      wb_valid  = 1'($urandom);
      wb_data   = $urandom;
      pick = -1;
      if (m_pend != 0 && $urandom_range(0, 9) != 0) begin
        pick = $urandom_range(0, NREGS - 1);
        while (!m_pend[pick]) pick = (pick + 1) % NREGS;
      end
      wb_addr = (pick >= 0) ? ADDR_W'(pick) : ADDR_W'($urandom_range(0, 7));
      #2;
      cycle();
    end

    // Drain, then reset mid-flight with r4 and r8 outstanding and a stall counted.
    for (int i = 1; i < NREGS; i++) begin
      if (m_pend[i]) begin
        drive(0, 0, 0, 0, 0, 0, 0, 1, i, 32'(i)); #2; cycle();
      end
    end
    drive(1, 0, 0, 0, 0, 1, 4, 0, 0, '0); #2; cycle();
    drive(1, 0, 0, 0, 0, 1, 8, 0, 0, '0); #2; cycle();
    drive(1, 4, 1, 0, 0, 0, 0, 0, 0, '0); #2; cycle();
    check("pre_rst_pend", 64'(pending), 64'h110);
    idle();
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    check("rst_pending", 64'(pending), 64'h0);
    check("rst_stall", 64'(stall_cnt), 64'h0);
    check("rst_err", 64'(wb_err), 64'h0);
    check("rst_ready", 64'(issue_ready), 64'h1);
    for (int i = 0; i < NREGS; i++) begin
      rs_addr = ADDR_W'(i);
      rt_addr = ADDR_W'(NREGS - 1 - i);
      #1;
      check("rst_rs_zero", 64'(rs_data), 64'h0);
      check("rst_rt_zero", 64'(rt_data), 64'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0, 1, 4, 32'h44); #2; cycle();
    check("late_wb_err", 64'(wb_err), 64'h1);

    // Stall counter saturation.
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0, '0); #2; cycle();
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, '0); #2;
    for (int n = 0; n < 65540; n++) cycle();
    check("stall_sat", 64'(stall_cnt), 64'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
